mole_hit_tracker: RTL and testbench

- Sits directly downstream of generateMoles; consumes its one-hot `molesGenerated` spawn requests.
- Keeps each of the 5 holes "up" for a fixed lifetime.
- Compares rising edges of the player's 5 hole keys against the live moles and emits registered hit/miss pulses.
- Maintains saturating score and miss counters for the display/FSM logic.

---
 rtl/mole_hit_tracker.sv | 139 +++++++++++++
 tb/tb_mole_hit_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_tracker.sv
// mole_hit_tracker
//   Tracks which of the holes currently have a mole up. It matches rising edges
//   of the player's keys against the live moles. It produces registered hit and
//   miss pulses and keeps saturating score and miss counters.
//
// Ports
//   clock          : system clock; all state updates happen on the rising edge.
//   reset          : synchronous, active-high reset. It has priority over everything.
//   enable         : game running. When low, all holes are forced idle.
//   molesGenerated : one-hot (or zero) spawn request. Bit i selects hole i.
//   keys           : debounced, active-high key levels. Bit i selects hole i.
//   activeMoles    : per-hole state (1 = mole up). This is the FSM state register.
//   hitPulse       : high for one cycle after an edge with at least one hit.
//   missPulse      : high for one cycle after an edge with at least one escape or whiff.
//   score          : saturating count of hits.
//   missCount      : saturating count of escapes plus whiffs.
//
// Handshake: there is no flow control. molesGenerated and keys are sampled on
// every rising edge. The outputs are registered and are valid every cycle.

module mole_hit_tracker #(
  parameter int NUM_HOLES = 5,
  parameter int MOLE_LIFE = 50000000,
  parameter int LIFE_W    = $clog2(MOLE_LIFE + 1),
  parameter int SCORE_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] molesGenerated,
  input  logic [NUM_HOLES-1:0] keys,
  output logic [NUM_HOLES-1:0] activeMoles,
  output logic                 hitPulse,
  output logic                 missPulse,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   missCount
);

  localparam logic [LIFE_W-1:0]  LIFE_LOAD = LIFE_W'(MOLE_LIFE - 1);
  localparam logic [SCORE_W+2:0] SUM_MAX   = {3'b000, {SCORE_W{1'b1}}};

  logic [NUM_HOLES-1:0] keys_d;
  logic [NUM_HOLES-1:0] press;
  logic [NUM_HOLES-1:0] active_next;
  logic [LIFE_W-1:0]    timer_q    [NUM_HOLES];
  logic [LIFE_W-1:0]    timer_next [NUM_HOLES];
  logic [NUM_HOLES-1:0] hit;
  logic [NUM_HOLES-1:0] escape;
  logic [NUM_HOLES-1:0] whiff;

  logic [SCORE_W+2:0]   hit_cnt;
  logic [SCORE_W+2:0]   miss_cnt;
  logic [SCORE_W+2:0]   score_sum;
  logic [SCORE_W+2:0]   miss_sum;
  logic [SCORE_W-1:0]   score_next;
  logic [SCORE_W-1:0]   miss_next;
  logic                 hit_pulse_next;
  logic                 miss_pulse_next;

  // A key press is a rising edge. A key that is held produces only one press.
  assign press = keys & ~keys_d;

  // State register: per-hole IDLE/UP state, lifetime timers, key history and outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      activeMoles <= '0;
      keys_d      <= '0;
      hitPulse    <= 1'b0;
      missPulse   <= 1'b0;
      score       <= '0;
      missCount   <= '0;
      for (int i = 0; i < NUM_HOLES; i++) timer_q[i] <= '0;
    end else begin
      activeMoles <= active_next;
      keys_d      <= keys;
      hitPulse    <= hit_pulse_next;
      missPulse   <= miss_pulse_next;
      score       <= score_next;
      missCount   <= miss_next;
      for (int i = 0; i < NUM_HOLES; i++) timer_q[i] <= timer_next[i];
    end
  end

  // Next-state logic. Each hole is independent and uses its pre-edge state.
  // The timer counts the remaining cycles after the current one, so it is
  // loaded with MOLE_LIFE-1. An up mole with timer 0 escapes unless it is hit
  // on this edge.
  always_comb begin
    active_next = activeMoles;
    hit         = '0;
    escape      = '0;
    whiff       = '0;
    for (int i = 0; i < NUM_HOLES; i++) timer_next[i] = timer_q[i];

    for (int i = 0; i < NUM_HOLES; i++) begin
      if (!enable) begin
        active_next[i] = 1'b0;
        timer_next[i]  = '0;
      end else if (activeMoles[i]) begin
        // A spawn request for a hole that is already up is dropped.
        if (press[i]) begin
          hit[i]         = 1'b1;
          active_next[i] = 1'b0;
          timer_next[i]  = '0;
        end else if (timer_q[i] != '0) begin
          timer_next[i]  = timer_q[i] - 1'b1;
        end else begin
          escape[i]      = 1'b1;
          active_next[i] = 1'b0;
        end
      end else begin
        // A press on an empty hole is a whiff, even if a spawn lands on the same edge.
        if (press[i]) whiff[i] = 1'b1;
        if (molesGenerated[i]) begin
          active_next[i] = 1'b1;
          timer_next[i]  = LIFE_LOAD;
        end
      end
    end
  end

  // Output logic: pulse and counter next values. The sums have three bits of
  // headroom, so a full-width popcount cannot wrap before saturation.
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      hit_cnt  = hit_cnt  + (SCORE_W+3)'(hit[i]);
      miss_cnt = miss_cnt + (SCORE_W+3)'(escape[i] | whiff[i]);
    end
    score_sum       = {3'b000, score} + hit_cnt;
    miss_sum        = {3'b000, missCount} + miss_cnt;
    score_next      = (score_sum > SUM_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    miss_next       = (miss_sum  > SUM_MAX) ? {SCORE_W{1'b1}} : miss_sum[SCORE_W-1:0];
    hit_pulse_next  = |hit;
    miss_pulse_next = |(escape | whiff);
  end

endmodule

// File: tb/tb_mole_hit_tracker.sv
// tb_mole_hit_tracker
//   Directed bench for mole_hit_tracker with MOLE_LIFE=4 and SCORE_W=3.
//   Inputs change 1 ns after a rising edge. Outputs are sampled at that same
//   point, so every check sees the result of the edge that was just taken.

module tb_mole_hit_tracker;

  localparam int LIFE = 4;
  localparam int SW   = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [4:0]    molesGenerated;
  logic [4:0]    keys;
  logic [4:0]    activeMoles;
  logic          hitPulse;
  logic          missPulse;
  logic [SW-1:0] score;
  logic [SW-1:0] missCount;

  int n_cmp = 0;
  int n_bad = 0;

  mole_hit_tracker #(
    .NUM_HOLES(5),
    .MOLE_LIFE(LIFE),
    .SCORE_W  (SW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .molesGenerated(molesGenerated),
    .keys          (keys),
    .activeMoles   (activeMoles),
    .hitPulse      (hitPulse),
    .missPulse     (missPulse),
    .score         (score),
    .missCount     (missCount)
  );

  // Clock and reset
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    molesGenerated = '0;
    keys           = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] act, input logic hp,
                           input logic mp, input logic [SW-1:0] sc, input logic [SW-1:0] mc);
    check({tag, ".active"}, 32'(activeMoles), 32'(act));
    check({tag, ".hitPulse"}, 32'(hitPulse), 32'(hp));
    check({tag, ".missPulse"}, 32'(missPulse), 32'(mp));
    check({tag, ".score"}, 32'(score), 32'(sc));
    check({tag, ".missCount"}, 32'(missCount), 32'(mc));
  endtask

  initial begin
    enable         = 1'b0;
    molesGenerated = '0;
    keys           = '0;
    do_reset();
    check_all("por", 5'b00000, 0, 0, 0, 0);

    // Reset in the middle of a game with three moles up
    enable = 1'b1;
    molesGenerated = 5'b00001; step();
    molesGenerated = 5'b00010; step();
    molesGenerated = 5'b00100; step();
    molesGenerated = 5'b00000;
    check("three_up", 32'(activeMoles), 32'h07);
    do_reset();
    check_all("mid_reset", 5'b00000, 0, 0, 0, 0);
    // The timers must also be cleared, so no escape appears later
    step(); step(); step(); step(); step();
    check_all("post_reset_quiet", 5'b00000, 0, 0, 0, 0);

    // Escape: the mole stays up for exactly LIFE cycles
    molesGenerated = 5'b00100; step();
    molesGenerated = 5'b00000;
    check("esc_up0", 32'(activeMoles), 32'h04);
    for (int k = 1; k < LIFE; k++) begin
      step();
      check($sformatf("esc_up%0d", k), 32'(activeMoles), 32'h04);
    end
    step();
    check_all("esc_drop", 5'b00000, 0, 1, 0, 1);
    step();
    check_all("esc_after", 5'b00000, 0, 0, 0, 1);

    // Hit on the last cycle: the hit beats expiry
    do_reset();
    molesGenerated = 5'b00001; step();
    molesGenerated = 5'b00000;
    step(); step(); step();
    check("last_cycle_up", 32'(activeMoles), 32'h01);
    keys = 5'b00001; step();
    check_all("last_hit", 5'b00000, 1, 0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check_all($sformatf("held%0d", k), 5'b00000, 0, 0, 1, 0);
    end
    keys = 5'b00000; step();

    // Concurrent hit on hole 1 and whiff on hole 3
    do_reset();
    molesGenerated = 5'b00010; step();
    molesGenerated = 5'b00000;
    keys = 5'b01010; step();
    check_all("hit_whiff", 5'b00000, 1, 1, 1, 1);
    keys = 5'b00000; step();
    check_all("hit_whiff_after", 5'b00000, 0, 0, 1, 1);

    // A spawn on a hole that is already up does not refresh its timer
    do_reset();
    molesGenerated = 5'b00100; step();
    molesGenerated = 5'b00000;
    step(); step();                      // timer is now 1
    molesGenerated = 5'b00100; step();   // dropped; timer goes to 0
    molesGenerated = 5'b00000;
    check_all("respawn_kept", 5'b00100, 0, 0, 0, 0);
    step();
    check_all("respawn_drop", 5'b00000, 0, 1, 0, 1);

    // Spawn and press on an idle hole in the same edge: whiff, and the hole goes up
    molesGenerated = 5'b10000;
    keys           = 5'b10000; step();
    molesGenerated = 5'b00000;
    keys           = 5'b00000;
    check_all("spawn_press", 5'b10000, 0, 1, 0, 2);
    step();
    check_all("spawn_press_after", 5'b10000, 0, 0, 0, 2);

    // Score saturates at 2^SW-1
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      molesGenerated = 5'b00001; step();
      molesGenerated = 5'b00000;
      keys = 5'b00001; step();
      check($sformatf("sat_score%0d", k), 32'(score), (k > 7) ? 32'd7 : 32'(k));
      check($sformatf("sat_pulse%0d", k), 32'(hitPulse), 32'd1);
      keys = 5'b00000; step();
    end
    check("sat_miss", 32'(missCount), 32'd0);

    // Dropping enable clears the holes and freezes the counters
    molesGenerated = 5'b00010; step();
    molesGenerated = 5'b01000; step();
    molesGenerated = 5'b00000;
    check("two_up", 32'(activeMoles), 32'h0A);
    enable = 1'b0; step();
    check_all("dis_clear", 5'b00000, 0, 0, 7, 0);
    keys = 5'b11111; molesGenerated = 5'b00001; step();
    check_all("dis_press", 5'b00000, 0, 0, 7, 0);
    keys = 5'b00000; molesGenerated = 5'b00000; step();
    check_all("dis_release", 5'b00000, 0, 0, 7, 0);
    enable = 1'b1; step();
    check_all("reenable", 5'b00000, 0, 0, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
